// File: rtl/reg_file_mp.sv
// Dual-write, dual-read register file with busy scoreboard and post-reset clear FSM.
// Optional combinational write-to-read bypass: define REGFILE_BYPASS_EN.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite0,
    input  logic [ADDR_W-1:0] Rd0,
    input  logic [XLEN-1:0]   Write_data0,
    input  logic              RegWrite1,
    input  logic [ADDR_W-1:0] Rd1,
    input  logic [XLEN-1:0]   Write_data1,
    input  logic [ADDR_W-1:0] Rs1,
    input  logic [ADDR_W-1:0] Rs2,
    output logic [XLEN-1:0]   read_data1,
    output logic [XLEN-1:0]   read_data2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              ready
);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [XLEN-1:0]   mem [NREGS];
    logic [NREGS-1:0]  busy_reg, busy_next;
    logic [NREGS-1:0]  wen0, wen1, busy_set, busy_clr;
    logic              active;

    assign ready  = (state_reg == READY);
    // Traffic is only honoured in READY with reset released.
    assign active = ready && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_W'(NREGS - 1))
                    state_next = READY;
            end
            READY: state_next = READY;
            default: state_next = INIT;
        endcase
    end

    // Per-entry write enables and scoreboard set/clear terms; entry 0 is hardwired.
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_entry
            if (gi == 0) begin : g_zero
                assign wen0[gi]      = 1'b0;
                assign wen1[gi]      = 1'b0;
                assign busy_set[gi]  = 1'b0;
                assign busy_clr[gi]  = 1'b0;
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign wen0[gi]      = active && RegWrite0 && (Rd0 == ADDR_W'(gi));
                assign wen1[gi]      = active && RegWrite1 && (Rd1 == ADDR_W'(gi));
                assign busy_set[gi]  = active && issue_valid && (issue_rd == ADDR_W'(gi));
                assign busy_clr[gi]  = wen0[gi] || wen1[gi];
                // A same-cycle issue is a younger producer, so set beats clear.
                assign busy_next[gi] = busy_set[gi] || (busy_reg[gi] && !busy_clr[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    // Storage has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (reset && state_reg == INIT) begin
            mem[cnt_reg] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (wen1[i])
                    mem[i] <= Write_data1;
                else if (wen0[i])
                    mem[i] <= Write_data0;
            end
        end
    end

    always_comb begin
        read_data1 = '0;
        if (ready && Rs1 != '0) begin
            read_data1 = mem[Rs1];
`ifdef REGFILE_BYPASS_EN
            if (RegWrite1 && Rd1 == Rs1)
                read_data1 = Write_data1;
            else if (RegWrite0 && Rd0 == Rs1)
                read_data1 = Write_data0;
`endif
        end
    end

    always_comb begin
        read_data2 = '0;
        if (ready && Rs2 != '0) begin
            read_data2 = mem[Rs2];
`ifdef REGFILE_BYPASS_EN
            if (RegWrite1 && Rd1 == Rs2)
                read_data2 = Write_data1;
            else if (RegWrite0 && Rd0 == Rs2)
                read_data2 = Write_data0;
`endif
        end
    end

    assign rs1_busy = ready && busy_reg[Rs1];
    assign rs2_busy = ready && busy_reg[Rs2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default 32x32 configuration).
module tb_reg_file_mp;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWrite0, RegWrite1, issue_valid;
    logic [ADDR_W-1:0] Rd0, Rd1, Rs1, Rs2, issue_rd;
    logic [XLEN-1:0]   Write_data0, Write_data1, read_data1, read_data2;
    logic              rs1_busy, rs2_busy, ready;

    int checks   = 0;
    int failures = 0;
    int n;
    logic saw_nonzero;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegWrite0   (RegWrite0),
        .Rd0         (Rd0),
        .Write_data0 (Write_data0),
        .RegWrite1   (RegWrite1),
        .Rd1         (Rd1),
        .Write_data1 (Write_data1),
        .Rs1         (Rs1),
        .Rs2         (Rs2),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .ready       (ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: got %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_writes();
        RegWrite0   = 1'b0;
        RegWrite1   = 1'b0;
        issue_valid = 1'b0;
    endtask

    // Counts cycles with ready low (bounded), flagging any nonzero read_data1.
    task automatic wait_ready();
        n = 0;
        saw_nonzero = 1'b0;
        while (!ready && n < 100) begin
            if (read_data1 !== '0) saw_nonzero = 1'b1;
            tick();
            n++;
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_writes();
        Rd0 = '0; Rd1 = '0; Rs1 = '0; Rs2 = '0; issue_rd = '0;
        Write_data0 = '0; Write_data1 = '0;
        tick();
        tick();
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_rd1", read_data1, 32'd0);

        // Release reset; traffic offered during INIT must be ignored.
        reset = 1'b1;
        Rs1 = 5'd5; Rs2 = 5'd0;
        RegWrite0 = 1'b1; Rd0 = 5'd6; Write_data0 = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd6;
        wait_ready();
        idle_writes();
        check("init_len", n, 32'd32);
        check("init_rd1_zero", {31'b0, saw_nonzero}, 32'd0);
        check("cleared_r5", read_data1, 32'd0);
        Rs1 = 5'd6; Rs2 = 5'd6;
        #1;
        check("init_write_ignored", read_data1, 32'd0);
        check("init_issue_ignored", {31'b0, rs2_busy}, 32'd0);

        // Dual write to distinct registers.
        RegWrite0 = 1'b1; Rd0 = 5'd1; Write_data0 = 32'hA5A5_A5A5;
        RegWrite1 = 1'b1; Rd1 = 5'd2; Write_data1 = 32'h5A5A_5A5A;
        tick();
        idle_writes();
        Rs1 = 5'd1; Rs2 = 5'd2;
        #1;
        check("wr_p0_r1", read_data1, 32'hA5A5_A5A5);
        check("wr_p1_r2", read_data2, 32'h5A5A_5A5A);

        // Same destination on both ports: port 1 wins.
        RegWrite0 = 1'b1; Rd0 = 5'd3; Write_data0 = 32'h1111_1111;
        RegWrite1 = 1'b1; Rd1 = 5'd3; Write_data1 = 32'hDEAD_BEEF;
        tick();
        idle_writes();
        Rs1 = 5'd3;
        #1;
        check("wr_conflict_r3", read_data1, 32'hDEAD_BEEF);

        // Writes to x0 are discarded (also not bypassed).
        RegWrite0 = 1'b1; Rd0 = 5'd0; Write_data0 = 32'hFFFF_FFFF;
        Rs1 = 5'd0;
        #1;
        check("x0_same_cycle", read_data1, 32'd0);
        tick();
        idle_writes();
        #1;
        check("x0_after", read_data1, 32'd0);

        // Same-cycle write and read of r4.
        RegWrite0 = 1'b1; Rd0 = 5'd4; Write_data0 = 32'hCAFE_BABE;
        Rs1 = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r4_same_cycle", read_data1, 32'hCAFE_BABE);
`else
        check("r4_same_cycle", read_data1, 32'd0);
`endif
        tick();
        idle_writes();
        #1;
        check("r4_next_cycle", read_data1, 32'hCAFE_BABE);

        // Both ports hit r8 while Rs2 reads it: port 1 value is the result.
        RegWrite0 = 1'b1; Rd0 = 5'd8; Write_data0 = 32'h0000_0001;
        RegWrite1 = 1'b1; Rd1 = 5'd8; Write_data1 = 32'h0000_0002;
        Rs2 = 5'd8;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r8_bypass_prio", read_data2, 32'h0000_0002);
`else
        check("r8_bypass_prio", read_data2, 32'd0);
`endif
        tick();
        idle_writes();
        #1;
        check("r8_after", read_data2, 32'h0000_0002);

        // Scoreboard: issue sets, writeback clears, same-cycle set wins.
        issue_valid = 1'b1; issue_rd = 5'd7;
        Rs1 = 5'd7; Rs2 = 5'd7;
        #1;
        check("busy7_before", {31'b0, rs1_busy}, 32'd0);
        tick();
        idle_writes();
        #1;
        check("busy7_set_rs1", {31'b0, rs1_busy}, 32'd1);
        check("busy7_set_rs2", {31'b0, rs2_busy}, 32'd1);
        RegWrite0 = 1'b1; Rd0 = 5'd7; Write_data0 = 32'h0000_0077;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle_writes();
        #1;
        check("busy7_set_wins", {31'b0, rs1_busy}, 32'd1);
        RegWrite1 = 1'b1; Rd1 = 5'd7; Write_data1 = 32'h0000_0078;
        tick();
        idle_writes();
        #1;
        check("busy7_clr_p1", {31'b0, rs1_busy}, 32'd0);
        check("r7_value", read_data1, 32'h0000_0078);

        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        idle_writes();
        Rs2 = 5'd9;
        #1;
        check("busy9_set", {31'b0, rs2_busy}, 32'd1);
        RegWrite0 = 1'b1; Rd0 = 5'd9; Write_data0 = 32'h0000_0099;
        tick();
        idle_writes();
        #1;
        check("busy9_clr_p0", {31'b0, rs2_busy}, 32'd0);

        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        idle_writes();
        Rs1 = 5'd0;
        #1;
        check("busy0_never", {31'b0, rs1_busy}, 32'd0);

        // Mid-operation reset with busy[7] set and r1..r3 holding data.
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        idle_writes();
        Rs1 = 5'd7;
        #1;
        check("busy7_pre_rst", {31'b0, rs1_busy}, 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_ready_low", {31'b0, ready}, 32'd0);
        check("rst_busy_low", {31'b0, rs1_busy}, 32'd0);
        Rs1 = 5'd1;
        wait_ready();
        check("reinit_len", n, 32'd32);
        Rs2 = 5'd2;
        #1;
        check("reinit_r1", read_data1, 32'd0);
        check("reinit_r2", read_data2, 32'd0);
        Rs1 = 5'd3; Rs2 = 5'd7;
        #1;
        check("reinit_r3", read_data1, 32'd0);
        check("reinit_busy7", {31'b0, rs2_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised successor to the decode-stage register file. It has two write ports (ALU writeback and load writeback) and two combinational read ports. A per-register busy scoreboard tracks outstanding producers for hazard detection. After reset, a sequential init FSM clears the array one entry per cycle, so the storage maps onto SRAM-like arrays with no global clear. The block sits in the decode stage and feeds the operand muxes and the hazard unit.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers, power of two, at least 4
ADDR_W, 5, register index width; must equal log2(NREGS)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
RegWrite0  in  1  write enable, port 0 (ALU writeback)
Rd0  in  ADDR_W  destination index, port 0
Write_data0  in  XLEN  write data, port 0
RegWrite1  in  1  write enable, port 1 (load writeback)
Rd1  in  ADDR_W  destination index, port 1
Write_data1  in  XLEN  write data, port 1
Rs1  in  ADDR_W  read index A
Rs2  in  ADDR_W  read index B
read_data1  out  XLEN  read data A
read_data2  out  XLEN  read data B
issue_valid  in  1  an instruction writing issue_rd is issued this cycle
issue_rd  in  ADDR_W  destination of the issued instruction
rs1_busy  out  1  register Rs1 has an outstanding producer
rs2_busy  out  1  register Rs2 has an outstanding producer
ready  out  1  init complete, block accepts traffic

Behaviour:
- Reset (reset==0 at a rising edge):
  - state goes to INIT, clear counter goes to 0, all busy bits go to 0.
  - Array contents are not touched by reset itself.
  - Reset asserted mid-INIT or mid-READY restarts INIT from counter 0.
- INIT state:
  - Each cycle with reset==1: array[counter] <= 0 and counter increments.
  - Leaves INIT the cycle after counter==NREGS-1 is written, so ready rises exactly NREGS cycles after reset deasserts.
- While ready==0:
  - Write ports and issue are ignored.
  - read_data1/2 = 0; rs1_busy/rs2_busy = 0.
- READY state, writes (rising edge):
  - Port k writes array[Rdk] when RegWritek==1 and Rdk!=0.
  - If both ports target the same Rd, port 1 wins.
  - Writes to index 0 are discarded.
- Reads:
  - Combinational: read_dataN = array[RsN].
  - RsN==0 always returns 0.
  - Bypass behaviour is defined under Optional Feature.
- Scoreboard (READY state only):
  - issue_valid && issue_rd!=0 sets busy[issue_rd].
  - A write on either port with RegWrite==1 and Rd!=0 clears busy[Rd].
  - Set and clear of the same index in the same cycle: set wins, since the new producer is younger.
  - busy[0] is constant 0.
  - rsN_busy = busy[RsN], combinational. The bypass option does not mask busy.
- Output values in reset/INIT: read_data1=0, read_data2=0, rs1_busy=0, rs2_busy=0, ready=0.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - If RegWritek==1, Rdk==RsN and RsN!=0 in the same cycle, read_dataN returns Write_datak combinationally.
  - Port 1 has priority over port 0, matching the write priority.
  - Only active when ready==1.
- Undefined:
  - Reads return the pre-edge array value.
  - The new value is visible from the cycle after the write.

Test Plan:
- Release reset, hold Rs1=5, Rs2=0 -> ready=0 for exactly 32 cycles, read_data1=0 throughout. ready=1 on cycle 33; read_data1=0 (cleared).
- READY: write port0 Rd=1 32'hA5A5A5A5, port1 Rd=2 32'h5A5A5A5A in the same cycle. Next cycle Rs1=1, Rs2=2 -> read_data1=A5A5A5A5, read_data2=5A5A5A5A.
- Both ports write Rd=3: port0 32'h11111111, port1 32'hDEADBEEF -> reg3 reads DEADBEEF. Then write Rd=0 with 32'hFFFFFFFF -> Rs1=0 reads 0.
- Same-cycle write Rd=4 32'hCAFEBABE with Rs1=4:
  - With REGFILE_BYPASS_EN, read_data1=CAFEBABE in that cycle.
  - Without it, read_data1=old value (0) that cycle and CAFEBABE the next.
- Scoreboard:
  - issue_valid=1, issue_rd=7 -> next cycle Rs1=7 gives rs1_busy=1.
  - Same cycle: port0 writes Rd=7 and issue_rd=7 -> rs1_busy stays 1.
  - Later write Rd=7 with issue_valid=0 -> rs1_busy=0.
  - issue_rd=0 never sets busy.
- Mid-operation reset: with regs 1-3 written and busy[7]=1, pulse reset low 1 cycle -> ready=0 and rs1_busy=0 immediately. After 32 cycles ready=1 and regs 1-3 read 0.
